// File: rtl/word_shift_sched.sv
// Round-robin scheduler for two requesters sharing one rotate/shift unit; one op in flight at a time.
// Iterative 1-bit datapath by default (latency amt+2); define WSS_BARREL_EN for a single-cycle barrel step (latency 2).
module word_shift_sched #(
  parameter int W     = 8,
  parameter int AMT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [1:0]       req1_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_tag
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             tag_q, tag_d;
  logic             ptr_q, ptr_d;
  logic             grant0, grant1;

`ifdef WSS_BARREL_EN
  function automatic logic [W-1:0] barrel(input logic [W-1:0] x, input logic [1:0] op,
                                          input logic [AMT_W-1:0] n);
    int unsigned  sh;
    int unsigned  inv;
    logic [W-1:0] r;
    sh  = n;
    inv = W - sh;
    // inv==W shifts the wrap-around term out completely, so n=0 is identity
    case (op)
      2'b00:   r = (x >> sh) | (x << inv);
      2'b01:   r = (x << sh) | (x >> inv);
      2'b10:   r = x >> sh;
      default: r = W'($signed(x) >>> sh);
    endcase
    return r;
  endfunction
`else
  function automatic logic [W-1:0] step1(input logic [W-1:0] x, input logic [1:0] op);
    logic [W-1:0] r;
    case (op)
      2'b00:   r = {x[0], x[W-1:1]};
      2'b01:   r = {x[W-2:0], x[W-1]};
      2'b10:   r = {1'b0, x[W-1:1]};
      default: r = {x[W-1], x[W-1:1]};
    endcase
    return r;
  endfunction
`endif

  // Ties go to the requester named by the pointer
  assign grant0 = req0_valid & (~req1_valid | ~ptr_q);
  assign grant1 = req1_valid & (~req0_valid |  ptr_q);

  assign req0_ready = (state_q == IDLE) & ~rst & grant0;
  assign req1_ready = (state_q == IDLE) & ~rst & grant1;

  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_tag   = tag_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          tag_d   = grant1;
          data_d  = grant1 ? req1_data : req0_data;
          cnt_d   = grant1 ? req1_amt  : req0_amt;
          op_d    = grant1 ? req1_op   : req0_op;
          ptr_d   = ~grant1;
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef WSS_BARREL_EN
        data_d  = barrel(data_q, op_q, cnt_q);
        cnt_d   = '0;
        state_d = DONE;
`else
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          data_d = step1(data_q, op_q);
          cnt_d  = cnt_q - 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      tag_q   <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_word_shift_sched.sv
// Scoreboard bench for word_shift_sched: accepts push expected results, an output monitor pops and compares.
// Works with or without WSS_BARREL_EN (only the expected latency changes).
module tb_word_shift_sched;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_data, req1_data;
  logic [AW-1:0] req0_amt, req1_amt;
  logic [1:0]    req0_op, req1_op;
  logic          out_valid, out_ready, out_tag;
  logic [W-1:0]  out_data;

  always #5 clk = ~clk;

  word_shift_sched #(.W(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  typedef struct {
    logic       tag;
    logic [7:0] data;
    int         acc_cyc;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic       acc_order[$];
  logic [7:0] exp0, exp1;
  logic       ptr_m;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       prev_v, prev_hs;
  bit         rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int lat_of(input logic [AW-1:0] a);
`ifdef WSS_BARREL_EN
    return 2;
`else
    return int'(a) + 2;
`endif
  endfunction

  function automatic logic [7:0] gold(input logic [1:0] op, input logic [7:0] x, input logic [2:0] a);
    logic [15:0] dbl;
    dbl = {x, x};
    case (op)
      2'b00:   begin dbl = dbl >> a; return dbl[7:0];  end
      2'b01:   begin dbl = dbl << a; return dbl[15:8]; end
      2'b10:   return x >> a;
      default: return 8'($signed(x) >>> a);
    endcase
  endfunction

  // Accept side: push the expected result for every handshake
  always @(negedge clk) begin
    if (rst) begin
      ptr_m = 1'b0;
    end else begin
      if (req0_valid && req1_valid && (req0_ready || req1_ready))
        chk("rr_grant", {30'd0, req1_ready, req0_ready}, ptr_m ? 32'd2 : 32'd1);
      if (req0_valid && req0_ready) begin
        sb.push_back('{1'b0, exp0, cyc, lat_of(req0_amt)});
        acc_order.push_back(1'b0);
        ptr_m = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1'b1, exp1, cyc, lat_of(req1_amt)});
        acc_order.push_back(1'b1);
        ptr_m = 1'b0;
      end
    end
  end

  // Output side: latency on the rising edge of out_valid, data/tag on handoff
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) chk("valid_drop_after_handoff", {31'd0, out_valid}, 32'd0);
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        else chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e.data});
        chk("out_tag", {31'd0, out_tag}, {31'd0, e.tag});
        chk("no_accept_at_handoff", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      prev_hs = out_valid && out_ready;
      prev_v  = out_valid;
    end
  end

  task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] d,
                         input logic [2:0] a, input logic [7:0] e);
    if (r == 0) begin
      req0_op = op; req0_data = d; req0_amt = a; exp0 = e; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_data = d; req1_amt = a; exp1 = e; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_acc(input int r);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (r == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout req%0d actual=no_accept required=accept", r);
    end
    @(posedge clk);
    #1;
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=pending=%0d required=pending=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    acc_order.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0;
    req0_op = '0; req1_op = '0; exp0 = '0; exp1 = '0;
    out_ready = 1'b1; rand_done = 0;

    // Reset values, with a valid request pending
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_tag", {31'd0, out_tag}, 32'd0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;

    // Directed single ops
    set_req(0, 2'b00, 8'hB4, 3'd3, 8'h96); wait_acc(0); wait_idle();
    set_req(1, 2'b01, 8'h81, 3'd1, 8'h03); wait_acc(1); wait_idle();
    set_req(0, 2'b10, 8'h80, 3'd7, 8'h01); wait_acc(0); wait_idle();
    set_req(0, 2'b11, 8'h80, 3'd7, 8'hFF); wait_acc(0); wait_idle();
    set_req(1, 2'b00, 8'h5A, 3'd0, 8'h5A); wait_acc(1); wait_idle();
    set_req(0, 2'b00, 8'h01, 3'd7, 8'h02); wait_acc(0); wait_idle();

    // Contention after reset: expect 0,1,0,1
    do_reset();
    set_req(0, 2'b01, 8'h0F, 3'd2, 8'h3C);
    set_req(1, 2'b10, 8'hF0, 3'd3, 8'h1E);
    wait_acc(0);
    set_req(0, 2'b11, 8'h70, 3'd1, 8'h38);
    wait_acc(1);
    set_req(1, 2'b01, 8'hC3, 3'd4, 8'h3C);
    wait_acc(0);
    wait_acc(1);
    wait_idle();
    chk("rr_count", acc_order.size(), 32'd4);
    if (acc_order.size() == 4)
      chk("rr_order", {28'd0, acc_order[0], acc_order[1], acc_order[2], acc_order[3]}, 32'h5);

    // Output backpressure held in DONE
    out_ready = 1'b0;
    set_req(0, 2'b01, 8'h12, 3'd4, 8'h21);
    wait_acc(0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    chk("stall_reached_done", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    set_req(1, 2'b00, 8'hAA, 3'd1, 8'h55);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {24'd0, out_data}, 32'h21);
      chk("stall_tag", {31'd0, out_tag}, 32'd0);
      chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_acc(1);
    wait_idle();

    // Reset in the middle of an op discards it
    set_req(0, 2'b11, 8'hC0, 3'd6, 8'hFF);
    wait_acc(0);
    rst = 1'b1;
    sb.delete();
    set_req(1, 2'b10, 8'hF0, 3'd4, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_data", {24'd0, out_data}, 32'd0);
      chk("rst_mid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_acc(1);
    wait_idle();

    // Random ops against the golden model with random output stalls
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int n = 0; n < 40; n++) begin
      int         mode;
      logic [1:0] o0, o1;
      logic [7:0] d0, d1;
      logic [2:0] a0, a1;
      mode = int'($urandom_range(0, 2));
      o0 = 2'($urandom_range(0, 3)); d0 = 8'($urandom_range(0, 255)); a0 = 3'($urandom_range(0, 7));
      o1 = 2'($urandom_range(0, 3)); d1 = 8'($urandom_range(0, 255)); a1 = 3'($urandom_range(0, 7));
      if (mode == 0) begin
        set_req(0, o0, d0, a0, gold(o0, d0, a0)); wait_acc(0);
      end else if (mode == 1) begin
        set_req(1, o1, d1, a1, gold(o1, d1, a1)); wait_acc(1);
      end else begin
        set_req(0, o0, d0, a0, gold(o0, d0, a0));
        set_req(1, o1, d1, a1, gold(o1, d1, a1));
        fork
          wait_acc(0);
          wait_acc(1);
        join
      end
    end
    rand_done = 1;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_idle();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
